// File: rtl/dmem_port_arbiter.sv
// Shares one single-port data memory between the core LSU and a DMA/loader engine.
// Fair core/DMA arbitration, locked DMA bursts, and a registered read response per port.
module dmem_port_arbiter #(
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [2:0]  core_size,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [2:0]  dma_size,
    input  logic [31:0] dma_wdata,
    input  logic        dma_last,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_size,
    output logic        mem_wen,
    input  logic [31:0] mem_rdata,
    output logic        dbg_state
);

    // Handshake: a requester holds req and its payload stable until gnt; gnt is
    // combinational in the same cycle, and the access completes at that cycle's edge.

    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic               core_rvalid_q, core_rvalid_d;
    logic               dma_rvalid_q, dma_rvalid_d;
    logic [31:0]        core_rdata_q, core_rdata_d;
    logic [31:0]        dma_rdata_q, dma_rdata_d;

    always_comb begin
        core_gnt = 1'b0;
        dma_gnt  = 1'b0;
        if (rst_n) begin
            if (state_q == ST_BURST) begin
                dma_gnt = dma_req;
            end else if ((wait_cnt_q == WAIT_W'(MAX_WAIT)) && dma_req) begin
                dma_gnt = 1'b1;
            end else if (core_req) begin
                core_gnt = 1'b1;
            end else if (dma_req) begin
                dma_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_size  = 3'b010;
        mem_wen   = 1'b0;
        if (core_gnt) begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            mem_size  = core_size;
            mem_wen   = core_we;
        end else if (dma_gnt) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_size  = dma_size;
            mem_wen   = dma_we;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ST_ARB: begin
                burst_cnt_d = '0;
                if (dma_gnt || !dma_req) begin
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
                if (dma_gnt && !dma_last) begin
                    state_d     = ST_BURST;
                    burst_cnt_d = BURST_W'(1);
                end
            end
            ST_BURST: begin
                wait_cnt_d  = '0;
                burst_cnt_d = burst_cnt_q + 1'b1;
                // Counter advances even on refused beats so a stalled DMA cannot hold the lock.
                if ((dma_gnt && dma_last) || (burst_cnt_d == BURST_W'(MAX_BURST))) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_comb begin
        core_rvalid_d = core_gnt && !core_we;
        dma_rvalid_d  = dma_gnt && !dma_we;
        core_rdata_d  = core_rvalid_d ? mem_rdata : core_rdata_q;
        dma_rdata_d   = dma_rvalid_d ? mem_rdata : dma_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_ARB;
            wait_cnt_q    <= '0;
            burst_cnt_q   <= '0;
            core_rvalid_q <= 1'b0;
            dma_rvalid_q  <= 1'b0;
            core_rdata_q  <= 32'h0;
            dma_rdata_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            burst_cnt_q   <= burst_cnt_d;
            core_rvalid_q <= core_rvalid_d;
            dma_rvalid_q  <= dma_rvalid_d;
            core_rdata_q  <= core_rdata_d;
            dma_rdata_q   <= dma_rdata_d;
        end
    end

    assign core_rvalid = core_rvalid_q;
    assign dma_rvalid  = dma_rvalid_q;
    assign core_rdata  = core_rdata_q;
    assign dma_rdata   = dma_rdata_q;
    assign dbg_state   = state_q;

endmodule
